// File: rtl/controle_semaforo_if.sv
// Traffic-light sequencer bus: timebase/request inputs and phase outputs.
interface controle_semaforo_if #(
  parameter int W = 8
);
  logic         habilita;
  logic         casoEsp;
  logic [1:0]   estado;
  logic [W-1:0] contador;
  logic         sinal;
  logic         sinal15;
  logic         pulso;
  logic         atendido;

  modport master (
    output habilita, casoEsp,
    input  estado, contador, sinal, sinal15, pulso, atendido
  );

  modport slave (
    input  habilita, casoEsp,
    output estado, contador, sinal, sinal15, pulso, atendido
  );
endinterface

// File: rtl/controle_semaforo.sv
// Four-phase traffic-light sequencer with tick-driven dwell counter
// and early green exit for pending special-case requests.
module controle_semaforo #(
  parameter int T_VERDE    = 30,
  parameter int T_AMARELO  = 5,
  parameter int T_VERMELHO = 30,
  parameter int T_TODOS    = 2,
  parameter int T_ESP      = 15,
  parameter int W          = 8
) (
  input logic           clk,
  input logic           reset,
  controle_semaforo_if.slave bus
);

  typedef enum logic [1:0] {
    VERDE    = 2'b00,
    AMARELO  = 2'b01,
    VERMELHO = 2'b10,
    TODOS    = 2'b11
  } fase_e;

  localparam logic [W-1:0] TV_M1 = W'(T_VERDE - 1);
  localparam logic [W-1:0] TA_M1 = W'(T_AMARELO - 1);
  localparam logic [W-1:0] TR_M1 = W'(T_VERMELHO - 1);
  localparam logic [W-1:0] TT_M1 = W'(T_TODOS - 1);
  localparam logic [W-1:0] TE_M1 = W'(T_ESP - 1);

  fase_e        estado_q, estado_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         pend_q, pend_d;
  logic         pulso_q, pulso_d;
  logic         atend_q, atend_d;

  logic [W-1:0] t_m1;
  logic         sinal, sinal15, avanca, consumo;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= VERDE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pulso_q  <= 1'b0;
      atend_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pulso_q  <= pulso_d;
      atend_q  <= atend_d;
    end
  end

  always_comb begin
    t_m1 = TV_M1;
    unique case (estado_q)
      VERDE:    t_m1 = TV_M1;
      AMARELO:  t_m1 = TA_M1;
      VERMELHO: t_m1 = TR_M1;
      TODOS:    t_m1 = TT_M1;
      default:  t_m1 = TV_M1;
    endcase

    sinal   = bus.habilita & (cnt_q == t_m1);
    sinal15 = bus.habilita & (estado_q == VERDE) & pend_q
            & (cnt_q >= TE_M1) & ~sinal;
    avanca  = sinal | sinal15;
    consumo = (estado_q == VERDE) & avanca & pend_q;

    estado_d = estado_q;
    cnt_d    = cnt_q;
    if (avanca) begin
      estado_d = fase_e'(estado_q + 2'd1);
      cnt_d    = '0;
    end else if (bus.habilita) begin
      cnt_d = cnt_q + W'(1);
    end

    // a request in the consume cycle survives for the next green
    pend_d  = bus.casoEsp | (pend_q & ~consumo);
    pulso_d = avanca;
    atend_d = consumo;
  end

  always_comb begin
    bus.estado   = estado_q;
    bus.contador = cnt_q;
    bus.sinal    = sinal;
    bus.sinal15  = sinal15;
    bus.pulso    = pulso_q;
    bus.atendido = atend_q;
  end

endmodule

// File: tb/tb_controle_semaforo.sv
// Randomized and directed checks of controle_semaforo against a
// phase/tick reference model.
module tb_controle_semaforo;

  localparam int TV = 6;
  localparam int TA = 2;
  localparam int TR = 4;
  localparam int TT = 1;
  localparam int TE = 3;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  controle_semaforo_if #(.W(W)) bus ();

  controle_semaforo #(
    .T_VERDE(TV), .T_AMARELO(TA), .T_VERMELHO(TR),
    .T_TODOS(TT), .T_ESP(TE), .W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int dur [4] = '{TV, TA, TR, TT};

  int m_p, m_e, m_pend, m_pul, m_at;
  bit valid = 0;
  int o_est, o_cnt, o_s, o_s15, o_pul, o_at;

  task automatic cyc(input bit hab, input bit ce, input bit rst);
    int s, s15, adv, cons;
    @(negedge clk);
    bus.habilita = hab;
    bus.casoEsp  = ce;
    reset        = rst;
    #1;
    o_est = int'(bus.estado);
    o_cnt = int'(bus.contador);
    o_s   = int'(bus.sinal);
    o_s15 = int'(bus.sinal15);
    o_pul = int'(bus.pulso);
    o_at  = int'(bus.atendido);
    s   = (hab && m_e == dur[m_p] - 1) ? 1 : 0;
    s15 = (hab && m_p == 0 && m_pend != 0
           && m_e >= TE - 1 && s == 0) ? 1 : 0;
    if (valid) begin
      chk("estado", o_est, m_p);
      chk("contador", o_cnt, m_e);
      chk("sinal", o_s, s);
      chk("sinal15", o_s15, s15);
      chk("pulso", o_pul, m_pul);
      chk("atendido", o_at, m_at);
    end
    adv  = s | s15;
    cons = (m_p == 0 && adv != 0 && m_pend != 0) ? 1 : 0;
    if (rst) begin
      m_p = 0; m_e = 0; m_pend = 0; m_pul = 0; m_at = 0;
      valid = 1;
    end else begin
      if (adv != 0) begin
        m_p = (m_p + 1) % 4;
        m_e = 0;
      end else if (hab) begin
        m_e++;
      end
      m_pend = (ce || (m_pend != 0 && cons == 0)) ? 1 : 0;
      m_pul  = adv;
      m_at   = cons;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
  endtask

  int exp_est [14] = '{0,0,0,0,0,0,1,1,2,2,2,2,3,0};
  int exp_pul [14] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,1};

  initial begin
    bus.habilita = 1'b0;
    bus.casoEsp  = 1'b0;

    // free run
    do_reset();
    for (int c = 0; c < 14; c++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("free_est_c%0d", c), o_est, exp_est[c]);
      chk($sformatf("free_pul_c%0d", c), o_pul, exp_pul[c]);
    end

    // early green exit, request in cycle 1 only
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, c == 1, 1'b0);
      if (c == 2) chk("esp_sinal15", o_s15, 1);
      if (c == 3) begin
        chk("esp_est", o_est, 1);
        chk("esp_pul", o_pul, 1);
        chk("esp_at", o_at, 1);
      end
    end

    // request during red, next green shortened
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(1'b1, c == 9, 1'b0);
      if (c == 16) begin
        chk("fora_est", o_est, 1);
        chk("fora_at", o_at, 1);
      end
    end

    // tick every third cycle
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc((c % 3) == 2, 1'b0, 1'b0);
      if (c == 17) chk("tick_est17", o_est, 0);
      if (c == 18) chk("tick_est18", o_est, 1);
    end

    // reset mid-phase with a pending request
    do_reset();
    for (int c = 0; c < 9; c++) begin
      cyc(1'b1, c == 6, c == 7);
      if (c == 8) begin
        chk("rst_est", o_est, 0);
        chk("rst_cnt", o_cnt, 0);
        chk("rst_pul", o_pul, 0);
      end
    end
    for (int c = 9; c < 16; c++) cyc(1'b1, 1'b0, 1'b0);

    // request held through consume cycle
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cyc(1'b1, c >= 1 && c <= 3, 1'b0);
      if (c == 13) begin
        chk("sobre_est", o_est, 1);
        chk("sobre_at", o_at, 1);
      end
    end

    // randomized
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom % 4) != 0, ($urandom % 10) == 0,
          ($urandom % 150) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
